// File: rtl/ro_freq_counter.sv
// ro_freq_counter: gated ring-oscillator frequency counter.
// Counts synchronized rising edges of ro_in over GATE_CYCLES clk_clk cycles
// and publishes the count on export_data with a valid/ready handshake.
module ro_freq_counter #(
    parameter int unsigned GATE_CYCLES = 50000,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk_clk,
    input  logic             reset_reset,
    input  logic             ro_in,
    input  logic             enable,
    input  logic             result_ready,
    output logic [CNT_W-1:0] export_data,
    output logic             result_valid,
    output logic             count_done,
    output logic             busy,
    output logic             overflow,
    output logic             overrun
);

    localparam int unsigned GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]  CNT_NEAR  = CNT_MAX - CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARM   = 2'd1,
        S_COUNT = 2'd2,
        S_LATCH = 2'd3
    } state_t;

    state_t                  state;
    logic [SYNC_STAGES-1:0]  sync_q;
    logic                    sync_prev;
    logic                    ro_rise_c;
    logic [CNT_W-1:0]        edge_cnt;
    logic [GATE_W-1:0]       gate_cnt;
    logic                    sat;

    // Synchronize ro_in into clk_clk and keep one extra flop for edge detect
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            sync_q    <= '0;
            sync_prev <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], ro_in};
            sync_prev <= sync_q[SYNC_STAGES-1];
        end
    end

    assign ro_rise_c = sync_q[SYNC_STAGES-1] & ~sync_prev;

    // Gate-window FSM, edge/gate counters, result register and handshake flags
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state        <= S_IDLE;
            edge_cnt     <= '0;
            gate_cnt     <= '0;
            sat          <= 1'b0;
            export_data  <= '0;
            result_valid <= 1'b0;
            count_done   <= 1'b0;
            busy         <= 1'b0;
            overflow     <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            count_done <= 1'b0;

            // Consumer pickup; a LATCH in the same cycle re-asserts below
            if (result_valid && result_ready) begin
                result_valid <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (enable) begin
                        state <= S_ARM;
                        busy  <= 1'b1;
                    end
                end

                S_ARM: begin
                    edge_cnt <= '0;
                    gate_cnt <= '0;
                    sat      <= 1'b0;
                    if (enable) begin
                        state <= S_COUNT;
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end

                S_COUNT: begin
                    if (!enable) begin
                        // Abort: discard the partial window, keep the last result
                        state    <= S_IDLE;
                        busy     <= 1'b0;
                        edge_cnt <= '0;
                        gate_cnt <= '0;
                        sat      <= 1'b0;
                    end else begin
                        gate_cnt <= gate_cnt + GATE_W'(1);
                        if (ro_rise_c) begin
                            if (edge_cnt != CNT_MAX) begin
                                edge_cnt <= edge_cnt + CNT_W'(1);
                            end
                            // Flag once the counter reaches its ceiling
                            if (edge_cnt >= CNT_NEAR) begin
                                sat <= 1'b1;
                            end
                        end
                        if (gate_cnt == GATE_LAST) begin
                            state      <= S_LATCH;
                            count_done <= 1'b1;
                        end
                    end
                end

                S_LATCH: begin
                    export_data  <= edge_cnt;
                    overflow     <= sat;
                    result_valid <= 1'b1;
                    if (result_valid && !result_ready) begin
                        overrun <= 1'b1;
                    end
                    edge_cnt <= '0;
                    gate_cnt <= '0;
                    sat      <= 1'b0;
                    if (enable) begin
                        state <= S_COUNT;
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ro_freq_counter.sv
// Directed self-checking bench for ro_freq_counter.
// ro_in is driven from a cycle-indexed pattern so edge counts per window are exact.
module tb_ro_freq_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst   = 1'b1;
    logic ro    = 1'b0;
    logic en    = 1'b0;
    logic rdy   = 1'b0;
    logic en_s  = 1'b0;
    logic rdy_s = 1'b0;

    logic [31:0] data;
    logic        valid, done, busy, ovf, ovr;
    logic [3:0]  data_s;
    logic        valid_s, done_s, busy_s, ovf_s, ovr_s;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int base   = 0;
    int mode   = 0;
    int n      = 0;
    bit saw    = 1'b0;

    ro_freq_counter #(.GATE_CYCLES(16), .CNT_W(32), .SYNC_STAGES(2)) dut (
        .clk_clk      (clk),
        .reset_reset  (rst),
        .ro_in        (ro),
        .enable       (en),
        .result_ready (rdy),
        .export_data  (data),
        .result_valid (valid),
        .count_done   (done),
        .busy         (busy),
        .overflow     (ovf),
        .overrun      (ovr)
    );

    ro_freq_counter #(.GATE_CYCLES(64), .CNT_W(4), .SYNC_STAGES(2)) dut_sat (
        .clk_clk      (clk),
        .reset_reset  (rst),
        .ro_in        (ro),
        .enable       (en_s),
        .result_ready (rdy_s),
        .export_data  (data_s),
        .result_valid (valid_s),
        .count_done   (done_s),
        .busy         (busy_s),
        .overflow     (ovf_s),
        .overrun      (ovr_s)
    );

    // mode 0: low; 1: period 4; 2: period 4 for 16 cycles then period 8
    function automatic logic ro_pat(input int m, input int r);
        case (m)
            1:       return (r % 4) >= 2;
            2:       return (r < 16) ? ((r % 4) >= 2) : (((r - 16) % 8) >= 4);
            default: return 1'b0;
        endcase
    endfunction

    task automatic step();
        @(negedge clk);
        cyc++;
        ro = ro_pat(mode, cyc - base);
    endtask

    task automatic set_base(input int m);
        mode = m;
        base = cyc;
        ro   = ro_pat(m, 0);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Steps until count_done of the selected instance, bounded
    task automatic wait_done(input bit sel, input int bound, output int cnt);
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (((sel ? done_s : done) == 1'b0) && (cnt < bound));
    endtask

    initial begin
        step();
        step();
        chk("rst_data",    data, 0);
        chk("rst_valid",   32'(valid), 0);
        chk("rst_done",    32'(done), 0);
        chk("rst_busy",    32'(busy), 0);
        chk("rst_ovf",     32'(ovf), 0);
        chk("rst_ovr",     32'(ovr), 0);
        chk("rst_data_s",  32'(data_s), 0);
        rst = 1'b0;
        step();

        // Continuous mode, no consumer: window 1 = 4 edges, window 2 = 2 edges
        en = 1'b1;
        set_base(2);
        wait_done(1'b0, 100, n);
        chk("t2_latency",  n, 18);
        chk("t2_busy_lat", 32'(busy), 1);
        chk("t2_valid_pre", 32'(valid), 0);
        step();
        chk("t2_data1",    data, 4);
        chk("t2_valid1",   32'(valid), 1);
        chk("t2_ovf1",     32'(ovf), 0);
        chk("t2_ovr1",     32'(ovr), 0);
        chk("t2_done_low", 32'(done), 0);
        wait_done(1'b0, 100, n);
        chk("t2_period",   n, 16);
        en = 1'b0;
        step();
        chk("t2_data2",    data, 2);
        chk("t2_valid2",   32'(valid), 1);
        chk("t2_ovr2",     32'(ovr), 1);
        chk("t2_busy_off", 32'(busy), 0);

        // Consumer pickup: valid drops, overrun is sticky
        rdy = 1'b1;
        step();
        rdy = 1'b0;
        chk("t3_valid",    32'(valid), 0);
        chk("t3_ovr",      32'(ovr), 1);
        chk("t3_data",     data, 2);
        step();
        chk("t3_valid_hold", 32'(valid), 0);

        // Reset mid-COUNT with enable held high
        en = 1'b1;
        set_base(1);
        repeat (10) step();
        chk("t4_busy_cnt", 32'(busy), 1);
        rst = 1'b1;
        step();
        chk("t4_data",     data, 0);
        chk("t4_valid",    32'(valid), 0);
        chk("t4_ovr",      32'(ovr), 0);
        chk("t4_busy",     32'(busy), 0);
        chk("t4_done",     32'(done), 0);
        chk("t4_ovf",      32'(ovf), 0);
        rst = 1'b0;
        set_base(2);
        wait_done(1'b0, 100, n);
        chk("t4_latency",  n, 18);
        step();
        chk("t4_data1",    data, 4);
        chk("t4_valid1",   32'(valid), 1);

        // Ready asserted exactly in LATCH with a pending result
        wait_done(1'b0, 100, n);
        chk("t5_period",   n, 16);
        chk("t5_valid_pend", 32'(valid), 1);
        rdy = 1'b1;
        en  = 1'b0;
        step();
        rdy = 1'b0;
        chk("t5_valid",    32'(valid), 1);
        chk("t5_ovr",      32'(ovr), 0);
        chk("t5_data",     data, 2);
        chk("t5_busy",     32'(busy), 0);

        // Abort in COUNT cycle 8 of 16
        en = 1'b1;
        set_base(1);
        repeat (9) step();
        chk("t6_busy_cnt", 32'(busy), 1);
        en = 1'b0;
        step();
        chk("t6_busy",     32'(busy), 0);
        chk("t6_done",     32'(done), 0);
        saw = 1'b0;
        repeat (25) begin
            step();
            if (done) saw = 1'b1;
        end
        chk("t6_no_done",  32'(saw), 0);
        chk("t6_data",     data, 2);
        chk("t6_valid",    32'(valid), 1);
        chk("t6_ovr",      32'(ovr), 0);

        // Saturation: 16 edges into a 4-bit counter, then a quiet window
        en_s = 1'b1;
        set_base(1);
        wait_done(1'b1, 200, n);
        chk("t7_latency",  n, 66);
        en_s = 1'b0;
        step();
        chk("t7_data_sat", 32'(data_s), 15);
        chk("t7_ovf_sat",  32'(ovf_s), 1);
        chk("t7_valid",    32'(valid_s), 1);
        en_s = 1'b1;
        set_base(0);
        wait_done(1'b1, 200, n);
        chk("t7_latency2", n, 66);
        en_s = 1'b0;
        step();
        chk("t7_data_zero", 32'(data_s), 0);
        chk("t7_ovf_clr",  32'(ovf_s), 0);
        chk("t7_ovr",      32'(ovr_s), 1);
        chk("t7_busy",     32'(busy_s), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ro_freq_counter.md
Name: ro_freq_counter

Overview:
- Gated frequency counter that measures a free-running ring-oscillator output against the system clock.
- Publishes the edge count per gate window as a 32-bit word.
- Sits directly upstream of the nios2_b ring-oscillator conduit: its export_data drives that conduit's export_data input, and software reads the result.
- Also provides a valid/ready handshake and status flags so a polling master or DMA-style consumer can pick up each window exactly once.

Parameters:
- GATE_CYCLES, 50000, clk_clk cycles per measurement window (1 ms at 50 MHz); legal range 2 to 2^24.
- CNT_W, 32, edge-counter and export_data width; legal range 4 to 32.
- SYNC_STAGES, 2, flops in the ro_in synchronizer; legal range 2 to 4.

Ports:
- clk_clk  in  1  system clock.
- reset_reset  in  1  synchronous reset, active-high.
- ro_in  in  1  ring-oscillator output, asynchronous to clk_clk.
- enable  in  1  level; 1 = measure continuously, 0 = stop.
- result_ready  in  1  consumer accepts the result when result_valid=1 in the same cycle.
- export_data  out  CNT_W  last completed window count, zero-extended.
- result_valid  out  1  a new unconsumed result is present.
- count_done  out  1  one-cycle pulse when a window completes.
- busy  out  1  high in ARM, COUNT and LATCH.
- overflow  out  1  the last completed window saturated.
- overrun  out  1  sticky: a result was overwritten while unconsumed.

Behaviour:
- Clocking and reset
  - One clock domain.
  - Reset is synchronous, active-high, and has priority over everything else.
  - Reset values: all outputs 0, state IDLE, counters 0, synchronizer flops 0.
- Synchronizer and edge detect
  - ro_in passes through SYNC_STAGES flops, then one extra flop for edge detect.
  - A rising edge counts when the synchronized value is 1 and its previous value was 0.
  - Correct counts are guaranteed only for ro_in frequency below clk_clk/2 after any divider. Above that the count is undefined but must not hang the FSM.
- State machine (states IDLE, ARM, COUNT, LATCH)
  - IDLE: busy=0. If enable=1, go to ARM.
  - ARM: one cycle. Clear edge_cnt and gate_cnt, then go to COUNT. If enable=0, go to IDLE.
  - COUNT: exactly GATE_CYCLES cycles.
    - Each cycle: gate_cnt+1; edge_cnt+1 on a detected edge.
    - edge_cnt saturates at 2^CNT_W-1 and sets the internal sat flag; it never wraps.
    - An edge detected in the final COUNT cycle is included in the count.
    - enable=0 in any COUNT cycle aborts to IDLE next cycle. No result is produced and export_data, result_valid and overflow are unchanged.
  - LATCH: one cycle.
    - export_data <= edge_cnt; overflow <= sat; count_done=1.
    - Clear edge_cnt, gate_cnt and sat.
    - Edges in LATCH and ARM are not counted (one-cycle dead time between back-to-back windows).
    - Next state: COUNT if enable=1, else IDLE.
- Latency
  - enable rising while in IDLE at edge k: ARM in cycle k+1, COUNT in cycles k+2..k+GATE_CYCLES+1, LATCH in cycle k+GATE_CYCLES+2.
  - export_data and result_valid update at the end of the LATCH cycle.
  - Window period in continuous mode is GATE_CYCLES+1 cycles.
- Handshake
  - result_valid is set in LATCH.
  - It clears on a cycle where result_valid=1 and result_ready=1.
  - If LATCH coincides with a pending unconsumed result: the new data overwrites, result_valid stays 1, and overrun is set. If result_ready=1 in that same cycle, the old result is consumed and no overrun is flagged.
  - overrun clears only on reset.
- export_data holds its value through IDLE and aborted windows.

Test Plan:
- GATE_CYCLES=16, CNT_W=32, ro_in toggled every 2 clk (period 4) -> first count_done 18 cycles after enable; export_data=4 (±1 for synchronizer phase); overflow=0.
- CNT_W=4, GATE_CYCLES=64, ro_in period 4 (16 edges) -> export_data=15, overflow=1. Next window with ro_in held low -> export_data=0, overflow=0.
- Continuous mode with result_ready=0 for two windows -> result_valid stays 1, overrun=1 after the second LATCH, export_data = second count. Then result_ready pulse -> result_valid=0, overrun stays 1.
- result_ready=1 asserted exactly in a LATCH cycle with a pending result -> no overrun; result_valid=1 with the new data.
- enable dropped at COUNT cycle 8 of 16 -> IDLE next cycle, no count_done, export_data unchanged, busy=0.
- reset_reset asserted for one cycle mid-COUNT -> next cycle all outputs 0, state IDLE. With enable held 1, a fresh window completes GATE_CYCLES+2 cycles after reset deasserts.
